// File: rtl/arb_burst_scheduler.sv
// Round-robin burst scheduler: one downstream resource shared by NUM_REQUEST requesters,
// each grant held until its burst of beats is accepted or the requester withdraws.
module arb_burst_scheduler #(
    parameter int NUM_REQUEST     = 4,
    parameter int REQ_INDEX_WIDTH = $clog2(NUM_REQUEST) + 1,
    parameter int BURST_WIDTH     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               init_in,
    input  logic                               en_in,
    input  logic [NUM_REQUEST-1:0]             req_in,
    input  logic [NUM_REQUEST*BURST_WIDTH-1:0] burst_len_in,
    input  logic                               beat_ready_in,
    output logic                               granted_out,
    output logic [NUM_REQUEST-1:0]             grant_out,
    output logic [REQ_INDEX_WIDTH-1:0]         grant_idx_out,
    output logic                               beat_fire_out,
    output logic [BURST_WIDTH-1:0]             beat_cnt_out,
    output logic                               last_out,
    output logic                               abort_out
);

    localparam int SW = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          ptr_q, ptr_d;
    logic [SW-1:0]          idx_q, idx_d;
    logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic                   abort_q, abort_d;

    logic                   win_found;
    logic [SW-1:0]          win_idx;
    logic [BURST_WIDTH-1:0] win_len;
    logic                   in_burst;

    // Rotating priority: search starts one past the last winner and wraps.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQUEST; i++) begin
            if (!win_found && req_in[(int'(ptr_q) + i) % NUM_REQUEST]) begin
                win_found = 1'b1;
                win_idx   = SW'((int'(ptr_q) + i) % NUM_REQUEST);
            end
        end
        win_len = burst_len_in[int'(win_idx)*BURST_WIDTH +: BURST_WIDTH];
    end

    assign in_burst      = (state_q == BURST);
    assign beat_fire_out = in_burst && req_in[idx_q] && beat_ready_in;
    assign granted_out   = in_burst;
    assign grant_out     = in_burst ? (NUM_REQUEST'(1) << idx_q) : '0;
    assign grant_idx_out = in_burst ? REQ_INDEX_WIDTH'(idx_q) : '0;
    assign beat_cnt_out  = in_burst ? cnt_q : '0;
    assign last_out      = last_q;
    assign abort_out     = abort_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = 1'b0;
        abort_d = 1'b0;

        if (init_in) begin
            state_d = IDLE;
            ptr_d   = SW'(NUM_REQUEST - 1);
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_in && win_found) begin
                        state_d = BURST;
                        ptr_d   = win_idx;
                        idx_d   = win_idx;
                        cnt_d   = (win_len == '0) ? BURST_WIDTH'(1) : win_len;
                    end
                end
                BURST: begin
                    if (!req_in[idx_q]) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else if (beat_ready_in) begin
                        if (cnt_q == BURST_WIDTH'(1)) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            last_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q - BURST_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= SW'(NUM_REQUEST - 1);
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_arb_burst_scheduler.sv
// Directed bench for arb_burst_scheduler: a per-cycle vector table plus hand-written
// sequences for abort, zero-length bursts, enable gating, init and async reset.
module tb_arb_burst_scheduler;

    localparam int N  = 4;
    localparam int IW = $clog2(N) + 1;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_in;
    logic            en_in;
    logic [N-1:0]    req_in;
    logic [N*BW-1:0] burst_len_in;
    logic            beat_ready_in;
    logic            granted_out;
    logic [N-1:0]    grant_out;
    logic [IW-1:0]   grant_idx_out;
    logic            beat_fire_out;
    logic [BW-1:0]   beat_cnt_out;
    logic            last_out;
    logic            abort_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arb_burst_scheduler #(
        .NUM_REQUEST    (N),
        .REQ_INDEX_WIDTH(IW),
        .BURST_WIDTH    (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_in      (init_in),
        .en_in        (en_in),
        .req_in       (req_in),
        .burst_len_in (burst_len_in),
        .beat_ready_in(beat_ready_in),
        .granted_out  (granted_out),
        .grant_out    (grant_out),
        .grant_idx_out(grant_idx_out),
        .beat_fire_out(beat_fire_out),
        .beat_cnt_out (beat_cnt_out),
        .last_out     (last_out),
        .abort_out    (abort_out)
    );

    typedef struct {
        logic [N-1:0]    req;
        logic [N*BW-1:0] lens;
        logic            ready;
        logic            en;
        logic            init;
        logic            e_gnt;
        int              e_idx;
        logic            e_fire;
        int              e_cnt;
        logic            e_last;
        logic            e_abort;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N*BW-1:0] lens,
                         input logic ready, input logic en, input logic init);
        req_in        = req;
        burst_len_in  = lens;
        beat_ready_in = ready;
        en_in         = en;
        init_in       = init;
    endtask

    task automatic expect_out(input string tag, input logic gnt, input int idx, input logic fire,
                              input int cnt, input logic last, input logic abort);
        logic [N-1:0] onehot;
        onehot = gnt ? (N'(1) << idx) : '0;
        check({tag, ".granted"}, 32'(granted_out), 32'(gnt));
        check({tag, ".grant"}, 32'(grant_out), 32'(onehot));
        check({tag, ".idx"}, 32'(grant_idx_out), gnt ? 32'(idx) : 32'd0);
        check({tag, ".fire"}, 32'(beat_fire_out), 32'(fire));
        check({tag, ".cnt"}, 32'(beat_cnt_out), 32'(cnt));
        check({tag, ".last"}, 32'(last_out), 32'(last));
        check({tag, ".abort"}, 32'(abort_out), 32'(abort));
    endtask

    // Inputs settle 2 time units after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t v(input logic [N-1:0] req, input logic [N*BW-1:0] lens,
                               input logic ready, input logic en, input logic init,
                               input logic g, input int idx, input logic fire, input int cnt,
                               input logic last, input logic abort);
        vec_t r;
        r.req = req; r.lens = lens; r.ready = ready; r.en = en; r.init = init;
        r.e_gnt = g; r.e_idx = idx; r.e_fire = fire; r.e_cnt = cnt;
        r.e_last = last; r.e_abort = abort;
        return r;
    endfunction

    initial begin
        // Single requester, len 3, then regrant to 0 after one idle cycle.
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  1, 0, 1, 3, 0, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  1, 0, 1, 2, 0, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  1, 0, 1, 1, 0, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  1, 0, 1, 3, 0, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  1, 0, 1, 2, 0, 0));
        tbl.push_back(v(4'b0001, 16'h0003, 1, 1, 0,  1, 0, 1, 1, 0, 0));
        // Re-init while idle restores the pointer so requester 0 leads the rotation.
        tbl.push_back(v(4'b0000, 16'h0003, 1, 1, 1,  0, 0, 0, 0, 1, 0));
        // All requesting, len 2: rotation 0,1,2,3,0 with one idle cycle between grants.
        tbl.push_back(v(4'b1111, 16'h2222, 1, 1, 0,  0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(v(4'b1111, 16'h2222, 1, 1, 0,  1, k % 4, 1, 2, 0, 0));
            tbl.push_back(v(4'b1111, 16'h2222, 1, 1, 0,  1, k % 4, 1, 1, 0, 0));
            if (k < 4)
                tbl.push_back(v(4'b1111, 16'h2222, 1, 1, 0,  0, 0, 0, 0, 1, 0));
        end
        // Pointer now 0: requester 1 alone wins, len 4, ready toggling 1,0,1,0,1,1.
        tbl.push_back(v(4'b0010, 16'h0040, 1, 1, 0,  0, 0, 0, 0, 1, 0));
        tbl.push_back(v(4'b0010, 16'h0040, 1, 1, 0,  1, 1, 1, 4, 0, 0));
        tbl.push_back(v(4'b0010, 16'h0040, 0, 1, 0,  1, 1, 0, 3, 0, 0));
        tbl.push_back(v(4'b0010, 16'h0040, 1, 1, 0,  1, 1, 1, 3, 0, 0));
        tbl.push_back(v(4'b0010, 16'h0040, 0, 1, 0,  1, 1, 0, 2, 0, 0));
        tbl.push_back(v(4'b0010, 16'h0040, 1, 1, 0,  1, 1, 1, 2, 0, 0));
        tbl.push_back(v(4'b0010, 16'h0040, 1, 1, 0,  1, 1, 1, 1, 0, 0));
        tbl.push_back(v(4'b0000, 16'h0040, 1, 1, 0,  0, 0, 0, 0, 1, 0));

        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        #3;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        #9 rst = 1'b0;
        next_cycle();

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].req, tbl[r].lens, tbl[r].ready, tbl[r].en, tbl[r].init);
            #2;
            expect_out($sformatf("row%0d", r), tbl[r].e_gnt, tbl[r].e_idx, tbl[r].e_fire,
                       tbl[r].e_cnt, tbl[r].e_last, tbl[r].e_abort);
            next_cycle();
        end

        // Abort: requester 2 (len 5) drops after 2 beats; 3 wins next, no last pulse.
        drive(4'b1100, 16'h1500, 1, 1, 0); #2; expect_out("ab0", 0, 0, 0, 0, 0, 0); next_cycle();
        drive(4'b1100, 16'h1500, 1, 1, 0); #2; expect_out("ab1", 1, 2, 1, 5, 0, 0); next_cycle();
        drive(4'b1100, 16'h1500, 1, 1, 0); #2; expect_out("ab2", 1, 2, 1, 4, 0, 0); next_cycle();
        drive(4'b1000, 16'h1500, 1, 1, 0); #2; expect_out("ab3", 1, 2, 0, 3, 0, 0); next_cycle();
        drive(4'b1000, 16'h1500, 1, 1, 0); #2; expect_out("ab4", 0, 0, 0, 0, 0, 1); next_cycle();
        drive(4'b1000, 16'h1500, 1, 1, 0); #2; expect_out("ab5", 1, 3, 1, 1, 0, 0); next_cycle();
        drive(4'b0000, 16'h1500, 1, 1, 0); #2; expect_out("ab6", 0, 0, 0, 0, 1, 0); next_cycle();

        // Zero length is one beat; then en_in low mid-burst lets the burst finish but blocks regrant.
        drive(4'b0001, 16'h0000, 1, 1, 0); #2; expect_out("z0", 0, 0, 0, 0, 0, 0); next_cycle();
        drive(4'b0001, 16'h0000, 1, 0, 0); #2; expect_out("z1", 1, 0, 1, 1, 0, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 0, 0); #2; expect_out("z2", 0, 0, 0, 0, 1, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 1, 0); #2; expect_out("en0", 0, 0, 0, 0, 0, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 0, 0); #2; expect_out("en1", 1, 0, 1, 3, 0, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 0, 0); #2; expect_out("en2", 1, 0, 1, 2, 0, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 0, 0); #2; expect_out("en3", 1, 0, 1, 1, 0, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 0, 0); #2; expect_out("en4", 0, 0, 0, 0, 1, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 0, 0); #2; expect_out("en5", 0, 0, 0, 0, 0, 0); next_cycle();
        drive(4'b0001, 16'h0003, 1, 1, 0); #2; expect_out("en6", 0, 0, 0, 0, 0, 0); next_cycle();

        // Init mid-burst: outputs clear with no last pulse; pointer back to 3 so 1010 grants 1.
        drive(4'b0001, 16'h0023, 1, 1, 1); #2; expect_out("in0", 1, 0, 1, 3, 0, 0); next_cycle();
        drive(4'b1010, 16'h0023, 1, 1, 0); #2; expect_out("in1", 0, 0, 0, 0, 0, 0); next_cycle();
        drive(4'b1010, 16'h0023, 1, 1, 0); #2; expect_out("in2", 1, 1, 1, 2, 0, 0); next_cycle();
        drive(4'b1010, 16'h0023, 0, 1, 0); #2; expect_out("in3", 1, 1, 0, 1, 0, 0);

        // Async reset mid-burst clears outputs before the next edge.
        rst = 1'b1;
        #1;
        expect_out("arst", 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        drive(4'b1111, 16'h1111, 1, 1, 0);
        next_cycle();
        expect_out("post_rst", 1, 0, 1, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_burst_scheduler.md
Name: arb_burst_scheduler

Overview:
Round-robin scheduler that shares one downstream resource among NUM_REQUEST requesters and holds each grant for a whole burst of beats. Each requester supplies a burst length. The grant stays locked until that many beats have been accepted by the resource, or until the requester withdraws. It sits between the requester ports and the shared resource, and extends the plain per-cycle arbiter with burst locking and beat counting.

Parameters:
NUM_REQUEST, 4, number of requesters (>=2)
REQ_INDEX_WIDTH, $clog2(NUM_REQUEST)+1, width of grant_idx_out
BURST_WIDTH, 4, width of each per-requester burst-length field

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
init_in  in  1  synchronous re-init: state to IDLE, pointer to reset value
en_in  in  1  enables new grants; an in-flight burst is unaffected
req_in  in  NUM_REQUEST  request per requester, level, held for whole burst
burst_len_in  in  NUM_REQUEST*BURST_WIDTH  beats per burst; field i = bits [i*BURST_WIDTH +: BURST_WIDTH]
beat_ready_in  in  1  resource accepts a beat this cycle
granted_out  out  1  a burst grant is active
grant_out  out  NUM_REQUEST  one-hot grant, all zero when idle
grant_idx_out  out  REQ_INDEX_WIDTH  index of granted requester, 0 when idle
beat_fire_out  out  1  beat accepted this cycle (combinational)
beat_cnt_out  out  BURST_WIDTH  beats remaining, including the current one
last_out  out  1  1-cycle pulse, registered, the cycle after the final beat
abort_out  out  1  1-cycle pulse, registered, the cycle after a requester drops mid-burst

Behaviour:
- Reset (rst=1, async): state IDLE, all outputs 0. rr_ptr = NUM_REQUEST-1, so requester 0 has first priority.
- States: IDLE, BURST.
- IDLE, en_in=1, |req_in:
  - Winner = first set req_in bit searching from rr_ptr+1 upward, with modulo wrap.
  - Next edge: BURST, grant_out/granted_out/grant_idx_out registered.
  - rr_ptr <= winner; cnt <= burst_len of winner. A burst_len of 0 is treated as 1.
  - Grant latency: 1 cycle from request sample.
- IDLE, en_in=0 or no request: stay IDLE, outputs 0.
- BURST:
  - beat_fire_out = req_in[idx] & beat_ready_in.
  - On fire with cnt>1: cnt decrements.
  - On fire with cnt==1: next edge goes to IDLE, grant drops, last_out=1 for one cycle.
  - Winner's burst_len is sampled only at grant; later changes are ignored.
  - beat_cnt_out shows cnt in BURST, 0 in IDLE.
- Requester drops req_in[idx] while in BURST:
  - beat_fire_out=0 that cycle.
  - Next edge: IDLE, abort_out=1 for one cycle.
  - No last_out; rr_ptr keeps the aborted index.
- After every burst end (last or abort), granted_out is low for at least 1 cycle, because IDLE is the re-arbitration cycle. Minimum period between grants = burst beats + 1.
- en_in deasserted during BURST: burst completes normally; no new grant until en_in=1.
- init_in=1 (synchronous): next edge sets state IDLE, rr_ptr=NUM_REQUEST-1, cnt=0, all outputs 0, no last/abort pulse. init_in has priority over every other transition.
- Reset asserted mid-burst: all outputs go to 0 immediately (async).
- Non-requesting requesters never receive a grant. grant_out is always one-hot or zero.
- Fairness: with all requests held high, grants rotate 0,1,2,3,0,… and each requester waits at most NUM_REQUEST-1 bursts.

Test Plan:
1. Reset, then req_in=4'b0001, burst_len[0]=3, beat_ready_in=1 -> grant 1 cycle later; grant_idx_out=0 and beat_cnt_out 3,2,1 over 3 cycles; last_out pulse; grant low 1 cycle; regrant to 0.
2. req_in=4'b1111, all lens=2, ready=1 -> grant order 0,1,2,3,0; each grant lasts 2 cycles, separated by 1 idle cycle.
3. Grant to 1 with len=4; beat_ready_in toggles 1,0,1,0,1,1 -> beat_fire_out follows ready; last_out comes after the 4th accepted beat; cnt is held while ready=0.
4. Grant to 2 with len=5; drop req_in[2] after 2 beats -> abort_out pulse, no last_out; next winner is 3 if requesting.
5. burst_len=0 -> exactly 1 beat. en_in=0 mid-burst -> burst completes, then granted_out stays 0 until en_in=1.
6. init_in pulse mid-burst -> next cycle all outputs 0 and pointer restored; with req_in=4'b1010 the next grant goes to 1. Async rst mid-burst clears outputs without waiting for a clock edge.
